// File: rtl/simon_round_controller_pkg.sv
// Shared definitions for the Simon64/96 round controller: the FSM state
// type, the word width, and the default cipher constants.
package simon_round_controller_pkg;

  localparam int word_width = 32;

  // Simon z2 sequence; bit j of the sequence is z_sequence[61-j]
  localparam logic [61:0] default_z_sequence =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  // Key-schedule constant c = 2^32 - 4
  localparam logic [word_width-1:0] default_round_const = 32'hfffffffc;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simon_round_logic.sv
// Combinational Simon64/96 round plus one key-schedule step. Takes the
// current bank contents (x, y, k0..k2) and the z bit for this round, and
// produces the five words the bank should hold after the round.
module simon_round_logic
  import simon_round_controller_pkg::*;
#(
  parameter logic [word_width-1:0] round_const = default_round_const
) (
  input  logic [word_width-1:0] x,
  input  logic [word_width-1:0] y,
  input  logic [word_width-1:0] k0,
  input  logic [word_width-1:0] k1,
  input  logic [word_width-1:0] k2,
  input  logic                  z_bit,
  output logic [word_width-1:0] next_x,
  output logic [word_width-1:0] next_y,
  output logic [word_width-1:0] next_k0,
  output logic [word_width-1:0] next_k1,
  output logic [word_width-1:0] next_k2
);

  logic [word_width-1:0] f_x;
  logic [word_width-1:0] key_tmp;

  // Feistel round on (x, y) with round key k0, and the m=3 key schedule
  // that shifts the key window and appends the freshly derived word.
  always_comb begin
    f_x     = ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]};
    key_tmp = {k2[2:0], k2[31:3]} ^ {k2[3:0], k2[31:4]};
    next_x  = y ^ f_x ^ k0;
    next_y  = x;
    next_k0 = k1;
    next_k1 = k2;
    next_k2 = round_const ^ {{(word_width-1){1'b0}}, z_bit} ^ k0 ^ key_tmp;
  end

endmodule

// File: rtl/simon_round_controller.sv
// Simon64/96 encryption core sequencer. Drives the write enable and
// next-value buses of an external five-word register bank: loads the
// plaintext and key on start, runs one round per clock, then pulses done
// with the ciphertext readable from bank words 0 and 1.
module simon_round_controller
  import simon_round_controller_pkg::*;
#(
  parameter int                    rounds      = 42,
  parameter logic [61:0]           z_sequence  = default_z_sequence,
  parameter logic [word_width-1:0] round_const = default_round_const
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [word_width-1:0] pt_x,
  input  logic [word_width-1:0] pt_y,
  input  logic [word_width-1:0] key0,
  input  logic [word_width-1:0] key1,
  input  logic [word_width-1:0] key2,
  output logic                  busy,
  output logic                  done,
  output logic [word_width-1:0] ct_x,
  output logic [word_width-1:0] ct_y,
  output logic                  rf_write_enable,
  output logic [word_width-1:0] rf_in0,
  output logic [word_width-1:0] rf_in1,
  output logic [word_width-1:0] rf_in2,
  output logic [word_width-1:0] rf_in3,
  output logic [word_width-1:0] rf_in4,
  input  logic [word_width-1:0] rf_out0,
  input  logic [word_width-1:0] rf_out1,
  input  logic [word_width-1:0] rf_out2,
  input  logic [word_width-1:0] rf_out3,
  input  logic [word_width-1:0] rf_out4
);

  localparam logic [5:0] last_round = 6'(rounds - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] round_count;
  logic [5:0] round_count_next;
  logic [5:0] z_index;
  logic       z_bit;

  logic [word_width-1:0] round_x;
  logic [word_width-1:0] round_y;
  logic [word_width-1:0] round_k0;
  logic [word_width-1:0] round_k1;
  logic [word_width-1:0] round_k2;

  // The ciphertext is whatever the bank holds; it stays put in IDLE
  // because the bank is only written when a new start arrives.
  assign ct_x = rf_out0;
  assign ct_y = rf_out1;

  // Round i uses z[i], stored MSB-first in the sequence constant.
  assign z_index = 6'd61 - round_count;
  assign z_bit   = z_sequence[z_index];

  simon_round_logic #(
    .round_const (round_const)
  ) u_round_logic (
    .x       (rf_out0),
    .y       (rf_out1),
    .k0      (rf_out2),
    .k1      (rf_out3),
    .k2      (rf_out4),
    .z_bit   (z_bit),
    .next_x  (round_x),
    .next_y  (round_y),
    .next_k0 (round_k0),
    .next_k1 (round_k1),
    .next_k2 (round_k2)
  );

  // State and round counter registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      round_count <= 6'd0;
    end else begin
      state       <= state_next;
      round_count <= round_count_next;
    end
  end

  // Next-state, counter and bank-bus decode. IDLE presents the load
  // values and writes them only when start is high; RUN writes one round
  // per clock; DONE holds the bank for the one-cycle done pulse.
  always_comb begin
    state_next       = state;
    round_count_next = round_count;
    busy             = (state != IDLE);
    done             = 1'b0;
    rf_write_enable  = 1'b0;
    rf_in0           = round_x;
    rf_in1           = round_y;
    rf_in2           = round_k0;
    rf_in3           = round_k1;
    rf_in4           = round_k2;
    case (state)
      IDLE: begin
        rf_write_enable = start;
        rf_in0          = pt_x;
        rf_in1          = pt_y;
        rf_in2          = key0;
        rf_in3          = key1;
        rf_in4          = key2;
        if (start) begin
          state_next       = RUN;
          round_count_next = 6'd0;
        end
      end
      RUN: begin
        rf_write_enable  = 1'b1;
        round_count_next = round_count + 6'd1;
        if (round_count == last_round) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done             = 1'b1;
        state_next       = IDLE;
        round_count_next = 6'd0;
      end
      default: begin
        state_next       = IDLE;
        round_count_next = 6'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_simon_round_controller.sv
// Testbench for simon_round_controller. Provides the register bank the
// core expects, drives directed vectors and checks ciphertexts through a
// scoreboard queue drained by a done-triggered monitor.
module tb_simon_round_controller;

  localparam int rounds = 42;
  localparam logic [61:0] z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [31:0] std_k0 = 32'h03020100;
  localparam logic [31:0] std_k1 = 32'h0b0a0908;
  localparam logic [31:0] std_k2 = 32'h13121110;
  localparam logic [31:0] std_px = 32'h6f722067;
  localparam logic [31:0] std_py = 32'h6e696c63;
  localparam logic [31:0] std_cx = 32'h5ca2e27f;
  localparam logic [31:0] std_cy = 32'h111a8fc8;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic clk = 1'b0;
  logic reset;

  // Main core (42 rounds) and its bank
  logic        start;
  logic [31:0] pt_x, pt_y, key0, key1, key2;
  logic        busy, done, we;
  logic [31:0] ct_x, ct_y;
  logic [31:0] rf_in0, rf_in1, rf_in2, rf_in3, rf_in4;
  logic [31:0] b0, b1, b2, b3, b4;

  // Single-round core and its bank
  logic        start1;
  logic [31:0] pt1_x, pt1_y, key1_0, key1_1, key1_2;
  logic        busy1, done1, we1;
  logic [31:0] ct1_x, ct1_y;
  logic [31:0] r1_in0, r1_in1, r1_in2, r1_in3, r1_in4;
  logic [31:0] c0, c1, c2, c3, c4;

  simon_round_controller #(.rounds(rounds)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pt_x(pt_x), .pt_y(pt_y), .key0(key0), .key1(key1), .key2(key2),
    .busy(busy), .done(done), .ct_x(ct_x), .ct_y(ct_y),
    .rf_write_enable(we),
    .rf_in0(rf_in0), .rf_in1(rf_in1), .rf_in2(rf_in2), .rf_in3(rf_in3), .rf_in4(rf_in4),
    .rf_out0(b0), .rf_out1(b1), .rf_out2(b2), .rf_out3(b3), .rf_out4(b4)
  );

  simon_round_controller #(.rounds(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .pt_x(pt1_x), .pt_y(pt1_y), .key0(key1_0), .key1(key1_1), .key2(key1_2),
    .busy(busy1), .done(done1), .ct_x(ct1_x), .ct_y(ct1_y),
    .rf_write_enable(we1),
    .rf_in0(r1_in0), .rf_in1(r1_in1), .rf_in2(r1_in2), .rf_in3(r1_in3), .rf_in4(r1_in4),
    .rf_out0(c0), .rf_out1(c1), .rf_out2(c2), .rf_out3(c3), .rf_out4(c4)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency expectations
  always @(posedge clk) cyc <= cyc + 1;

  // Register banks: shared write enable, cleared by the shared reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      {b0, b1, b2, b3, b4} <= '0;
      {c0, c1, c2, c3, c4} <= '0;
    end else begin
      if (we)  {b0, b1, b2, b3, b4} <= {rf_in0, rf_in1, rf_in2, rf_in3, rf_in4};
      if (we1) {c0, c1, c2, c3, c4} <= {r1_in0, r1_in1, r1_in2, r1_in3, r1_in4};
    end
  end

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("ct_x", ct_x, e.x);
        checkOutput("ct_y", ct_y, e.y);
        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Per-round reference of the round and key schedule, driven from the
  // bank contents and the bench's own round count
  int rcount = 0;
  always @(negedge clk) begin
    if (reset) begin
      rcount = 0;
    end else if (busy && we) begin
      logic [31:0] fx, exp4;
      fx   = (rotl(b0, 1) & rotl(b0, 8)) ^ rotl(b0, 2);
      exp4 = 32'hfffffffc ^ {31'b0, z2[61 - rcount]} ^ b2 ^ rotr(b4, 3) ^ rotr(b4, 4);
      checkOutput("round_rf_in0", rf_in0, b1 ^ fx ^ b2);
      checkOutput("ks_rf_in4", rf_in4, exp4);
      if (rcount == 0 && b2 == std_k0 && b4 == std_k2)
        checkOutput("ks_first_word", rf_in4, 32'hffae9dce);
      rcount = rcount + 1;
    end else if (!busy && we) begin
      rcount = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std_inputs();
    pt_x = std_px; pt_y = std_py; key0 = std_k0; key1 = std_k1; key2 = std_k2;
  endtask

  task automatic set_junk_inputs();
    pt_x = 32'hdeadbeef; pt_y = 32'h01234567; key0 = 32'hffffffff;
    key1 = 32'h55aa55aa; key2 = 32'h0f0f0f0f;
  endtask

  // Raise start for one cycle and queue the standard ciphertext
  task automatic applyStimulus(output int start_cyc);
    start_cyc = cyc;
    start = 1'b1;
    sb.push_back('{std_cx, std_cy, cyc + rounds + 1});
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int c;
    int bad_we;
    reset = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    set_std_inputs();
    pt1_x = 32'd1; pt1_y = 32'd0; key1_0 = 32'd0; key1_1 = 32'd0; key1_2 = 32'd0;
    repeat (3) next_cycle();

    // Reset state
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);
    reset = 1'b0;
    next_cycle();

    // Single-round core: x=1, y=0, zero key
    start1 = 1'b1;
    next_cycle();
    start1 = 1'b0;
    @(negedge clk);
    checkOutput("r1_busy_run", 32'(busy1), 32'd1);
    checkOutput("r1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    checkOutput("r1_done", 32'(done1), 32'd1);
    checkOutput("r1_ct_x", ct1_x, 32'h00000004);
    checkOutput("r1_ct_y", ct1_y, 32'h00000001);
    @(negedge clk);
    checkOutput("r1_done_width", 32'(done1), 32'd0);
    checkOutput("r1_busy_drop", 32'(busy1), 32'd0);
    next_cycle();

    // Standard vector; start pulses and input changes during RUN/DONE ignored
    applyStimulus(c);
    set_junk_inputs();
    repeat (5) next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    while (cyc < c + rounds + 1) next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_drain(200);
    checkOutput("idle_after_done", 32'(busy), 32'd0);

    // Results hold while inputs wander with start low
    bad_we = 0;
    repeat (100) begin
      next_cycle();
      pt_x = pt_x + 32'd7;
      key2 = key2 ^ 32'h00010001;
      if (we !== 1'b0) bad_we++;
    end
    checkOutput("hold_we", 32'(bad_we), 32'd0);
    checkOutput("hold_ct_x", ct_x, std_cx);
    checkOutput("hold_ct_y", ct_y, std_cy);
    set_std_inputs();

    // Start held high: back-to-back encryptions every rounds+2 cycles
    c = cyc;
    start = 1'b1;
    sb.push_back('{std_cx, std_cy, c + rounds + 1});
    sb.push_back('{std_cx, std_cy, c + 2 * rounds + 3});
    while (cyc < c + rounds + 3) next_cycle();
    start = 1'b0;
    wait_drain(200);
    next_cycle();
    checkOutput("held_start_idle", 32'(busy), 32'd0);

    // Reset during round 20 aborts without a done pulse
    c = cyc;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    while (cyc < c + 21) next_cycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_we", 32'(we), 32'd0);
    checkOutput("abort_ct_x", ct_x, 32'd0);
    checkOutput("abort_ct_y", ct_y, 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Fresh run after the abort
    applyStimulus(c);
    wait_drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
